matmul_tile_scheduler: RTL and testbench
========================================

# matmul_tile_scheduler

Sequencing controller for the multi-core systolic matrix-multiply datapath. It walks every output tile of matrix C, row-major, in block units of `BLOCK_SIZE x BLOCK_SIZE`. For each tile it steps through all inner-dimension blocks, issuing A-block and B-block addresses to the input buffers and pulsing the core array's systolic reset and accumulator reset. It reports each completed C tile. It sits between the top-level start/done interface and the `core` instances, and replaces ad-hoc edge-triggered counter logic with a single-clock FSM.

## Interface
- `BLOCK_SIZE`, 2, systolic array dimension N.
- `INNER_DIMENSION`, 64, shared dimension of A and B; K = INNER_DIMENSION/BLOCK_SIZE inner blocks.
- `ROW_SIZE_MAT_A`, 16, rows of A; R = ROW_SIZE_MAT_A/BLOCK_SIZE tile rows.
- `COL_SIZE_MAT_B`, 10, columns of B; C = COL_SIZE_MAT_B/BLOCK_SIZE tile columns.
- `ADDR_WIDTH`, 16, width of block addresses; must hold max(R*K, C*K)-1.
- Ports:
  - `clk` in 1: sole clock, rising edge.
  - `rst` in 1: synchronous, active-high reset.
  - `start` in 1: one-cycle request to begin a full multiplication.
  - `busy` out 1: high from the cycle after accepted `start` until `done`.
  - `done` out 1: one-cycle pulse when the last tile has completed.
  - `addr_valid` out 1: A/B block addresses are valid.
  - `addr_ready` in 1: input buffers accept the addresses.
  - `addr_a` out ADDR_WIDTH: A block index = k + K*row.
  - `addr_b` out ADDR_WIDTH: B block index = k + K*col.
  - `core_rst_n` out 1: active-low systolic restart to all cores.
  - `core_reset_acc` out 1: accumulator clear to all cores.
  - `systolic_finish` in 1: level from cores, one block product is done.
  - `accumulator_done` in 1: level from cores, the tile accumulation is done.
  - `tile_valid` out 1: one-cycle pulse when a C tile is final.
  - `tile_row` out clog2(R): row of the tile reported by `tile_valid`.
  - `tile_col` out clog2(C): column of the tile reported by `tile_valid`.

## Operation
- FSM states: IDLE, LOAD, RUN, CLEAR, DRAIN, FIN.
- **IDLE**
  - Outputs: `core_rst_n`=0, `core_reset_acc`=1, `busy`=0.
  - `start` → LOAD; row, col and k are cleared to 0.
- **LOAD**
  - `addr_valid`=1; `core_rst_n`=0; `core_reset_acc`=1 only when k==0.
  - `addr_valid && addr_ready` → RUN.
- **RUN**
  - Outputs: `core_rst_n`=1, `core_reset_acc`=0.
  - Waits for `systolic_finish`.
  - On finish with k<K-1: k++, → CLEAR.
  - On finish with k==K-1: → DRAIN, or directly to tile completion if `accumulator_done` is also high that cycle.
- **CLEAR**
  - One cycle, `core_rst_n`=0 (accumulator retained), → LOAD.
- **DRAIN**
  - `core_rst_n`=0; waits for `accumulator_done`.
- **Tile completion**, on the transition out of DRAIN or the simultaneous-event path:
  - `tile_valid` pulses with the current row/col.
  - k is cleared to 0.
  - If col==C-1 and row==R-1 → FIN.
  - Otherwise col++ (wrapping to 0 with row++) → LOAD.
- **FIN**
  - `done`=1 for one cycle → IDLE.
- Handshake and input rules:
  - `start` is ignored when not in IDLE.
  - `addr_a`/`addr_b`/`addr_valid` are held stable while `addr_ready` is low.
  - `systolic_finish`/`accumulator_done` are ignored outside RUN/DRAIN.
- Address arithmetic:
  - Registered products K*row and K*col, updated on row/col change. No multiplier sits in the address path.
  - Unsigned arithmetic, no overflow permitted by the `ADDR_WIDTH` rule.
- Parameter legality: non-divisible parameters, K<1, R<1 or C<1 abort elaboration with a fatal error.
- Reset values:
  - `busy`, `done`, `addr_valid` and `tile_valid` = 0.
  - `core_rst_n`=0, `core_reset_acc`=1.
  - All addresses and tile indices = 0.

## Timing
- Outputs are registered and decoded from state.
- `start` accepted at edge n: `busy`=1 and `addr_valid`=1 from cycle n+1.
- Address handshake at edge m: `core_rst_n`=1 from cycle m+1.
- `systolic_finish` sampled high at edge p: CLEAR occupies cycle p+1, and `addr_valid` reasserts at cycle p+2.
- `accumulator_done` sampled at edge q: `tile_valid` at cycle q+1.
  - For the last tile, `done` follows at cycle q+2.
- Minimum overhead per inner block: 3 cycles (LOAD, CLEAR, handshake) plus the core latency.
- `rst` asserted in any state: FSM is in IDLE at the next edge with reset values. In-flight tiles are discarded and no `tile_valid` or `done` is emitted.

## Configuration
- `MATMUL_SCHED_PERF_EN` defined: adds outputs `perf_cycles` [31:0] and `perf_stall` [31:0].
  - `perf_cycles` counts cycles while `busy`.
  - `perf_stall` counts LOAD cycles with `addr_ready`=0.
  - Both clear on accepted `start` or `rst` and saturate at all-ones.
- Undefined: those ports and counters do not exist.

## Structure
- Shared package `matmul_pkg`: the FSM state enum and localparam helpers for K/R/C derivation. `core` and the top level reuse these.
- One natural sub-module, `tile_index_counter`: the nested k/col/row counter with wrap flags and registered K*row/K*col products. The FSM instantiates it.

## Test plan
- BLOCK_SIZE=2, INNER=8, ROW_A=4, COL_B=4 (K=4, R=2, C=2); core model finishes 5 cycles after restart; `addr_ready`=1 → `addr_a` sequence 0,1,2,3,0,1,2,3,4,5,6,7,4,5,6,7; `addr_b` 0–3,4–7,0–3,4–7; `tile_valid` at (0,0),(0,1),(1,0),(1,1); one `done` pulse.
- Hold `addr_ready`=0 for 10 cycles in the first LOAD → `addr_valid` stays 1, `addr_a`=0, `addr_b`=0 stable, `core_rst_n` stays 0.
- Assert `systolic_finish` and `accumulator_done` in the same cycle at k=3 → no DRAIN cycle; `tile_valid` the next cycle; the next LOAD has k=0 and `core_reset_acc`=1.
- Pulse `rst` during RUN of tile (1,0) → next cycle in IDLE, `core_rst_n`=0, `core_reset_acc`=1, no `done`; a new `start` restarts at addr 0/0.
- Pulse `start` while `busy` → ignored; the address sequence is identical to the first scenario.
- With `MATMUL_SCHED_PERF_EN` and scenario 2 → `perf_stall`=10 and `perf_cycles` equals the `busy`-high count.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul scheduler and core array: FSM state
// encoding and helpers that derive block counts and index widths.
package matmul_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StClear,
    StDrain,
    StFin
  } sched_state_e;

  // Number of whole blocks along a dimension; zero block size yields zero.
  function automatic int unsigned calc_blocks(input int unsigned dim, input int unsigned blk);
    return (blk == 0) ? 0 : dim / blk;
  endfunction

  // Index width for a counter over n values, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tile_index_counter.sv
// Nested k/col/row block counter for the tile scheduler. Keeps running K*row
// and K*col bases as registers (stepped by K on every row/col change) so the
// block addresses need only an adder. Addresses are registered from the
// next-state indices so they are valid in the same cycle as the new indices.
module tile_index_counter import matmul_pkg::*; #(
  parameter int unsigned K          = 32,
  parameter int unsigned R          = 8,
  parameter int unsigned C          = 5,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned KW         = idx_width(K),
  parameter int unsigned RW         = idx_width(R),
  parameter int unsigned CW         = idx_width(C)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  k_inc_i,
  input  logic                  tile_adv_i,
  output logic                  k_last_o,
  output logic                  tile_last_o,
  output logic [RW-1:0]         row_o,
  output logic [CW-1:0]         col_o,
  output logic [ADDR_WIDTH-1:0] addr_a_o,
  output logic [ADDR_WIDTH-1:0] addr_b_o
);

  logic [KW-1:0]         k_q, k_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [ADDR_WIDTH-1:0] col_base_q, col_base_d;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
  logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
  logic                  row_last, col_last;

  assign row_last = (row_q == RW'(R - 1));
  assign col_last = (col_q == CW'(C - 1));

  // Next-state of the nested counters and their K-scaled bases.
  always_comb begin
    k_d        = k_q;
    row_d      = row_q;
    col_d      = col_q;
    row_base_d = row_base_q;
    col_base_d = col_base_q;
    if (clear_i) begin
      k_d        = '0;
      row_d      = '0;
      col_d      = '0;
      row_base_d = '0;
      col_base_d = '0;
    end else if (tile_adv_i) begin
      k_d = '0;
      if (col_last) begin
        col_d      = '0;
        col_base_d = '0;
        if (row_last) begin
          row_d      = '0;
          row_base_d = '0;
        end else begin
          row_d      = row_q + 1'b1;
          row_base_d = row_base_q + ADDR_WIDTH'(K);
        end
      end else begin
        col_d      = col_q + 1'b1;
        col_base_d = col_base_q + ADDR_WIDTH'(K);
      end
    end else if (k_inc_i) begin
      k_d = k_q + 1'b1;
    end
    addr_a_d = ADDR_WIDTH'(k_d) + row_base_d;
    addr_b_d = ADDR_WIDTH'(k_d) + col_base_d;
  end

  // Counter and address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      row_base_q <= '0;
      col_base_q <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
    end else begin
      k_q        <= k_d;
      row_q      <= row_d;
      col_q      <= col_d;
      row_base_q <= row_base_d;
      col_base_q <= col_base_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
    end
  end

  assign k_last_o    = (k_q == KW'(K - 1));
  assign tile_last_o = row_last && col_last;
  assign row_o       = row_q;
  assign col_o       = col_q;
  assign addr_a_o    = addr_a_q;
  assign addr_b_o    = addr_b_q;

endmodule

// File: rtl/matmul_tile_scheduler.sv
// Tile scheduler for the systolic matmul datapath: walks C tiles row-major,
// steps through the K inner blocks of each, issues A/B block addresses and
// drives the cores' systolic and accumulator resets.
// Optional feature macro: MATMUL_SCHED_PERF_EN adds perf_cycles/perf_stall.
module matmul_tile_scheduler import matmul_pkg::*; #(
  parameter int unsigned BLOCK_SIZE      = 2,
  parameter int unsigned INNER_DIMENSION = 64,
  parameter int unsigned ROW_SIZE_MAT_A  = 16,
  parameter int unsigned COL_SIZE_MAT_B  = 10,
  parameter int unsigned ADDR_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  addr_valid,
  input  logic                  addr_ready,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic                  core_rst_n,
  output logic                  core_reset_acc,
  input  logic                  systolic_finish,
  input  logic                  accumulator_done,
  output logic                  tile_valid,
  output logic [idx_width(calc_blocks(ROW_SIZE_MAT_A, BLOCK_SIZE))-1:0] tile_row,
  output logic [idx_width(calc_blocks(COL_SIZE_MAT_B, BLOCK_SIZE))-1:0] tile_col
`ifdef MATMUL_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_cycles,
  output logic [31:0]           perf_stall
`endif
);

  localparam int unsigned K  = calc_blocks(INNER_DIMENSION, BLOCK_SIZE);
  localparam int unsigned R  = calc_blocks(ROW_SIZE_MAT_A, BLOCK_SIZE);
  localparam int unsigned C  = calc_blocks(COL_SIZE_MAT_B, BLOCK_SIZE);
  localparam int unsigned RW = idx_width(R);
  localparam int unsigned CW = idx_width(C);
  localparam longint unsigned MaxBlocks = (R > C) ? longint'(R) * K : longint'(C) * K;

  if (BLOCK_SIZE < 1 || (INNER_DIMENSION % BLOCK_SIZE) != 0 ||
      (ROW_SIZE_MAT_A % BLOCK_SIZE) != 0 || (COL_SIZE_MAT_B % BLOCK_SIZE) != 0 ||
      K < 1 || R < 1 || C < 1) begin : g_bad_dims
    $fatal(1, "matmul_tile_scheduler: illegal matrix/block dimensions");
  end
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 32 ||
      MaxBlocks > (64'd1 << ADDR_WIDTH)) begin : g_bad_addr
    $fatal(1, "matmul_tile_scheduler: ADDR_WIDTH too narrow for block indices");
  end

  sched_state_e    state_q;
  logic            cnt_clear, cnt_k_inc, cnt_tile_adv;
  logic            k_last, tile_last;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;

  // Counter strobes decoded from state and the core status levels.
  always_comb begin
    cnt_clear    = 1'b0;
    cnt_k_inc    = 1'b0;
    cnt_tile_adv = 1'b0;
    case (state_q)
      StIdle:  cnt_clear = start;
      StRun: begin
        if (systolic_finish) begin
          if (!k_last) cnt_k_inc = 1'b1;
          else         cnt_tile_adv = accumulator_done;
        end
      end
      StDrain: cnt_tile_adv = accumulator_done;
      default: ;
    endcase
  end

  tile_index_counter #(
    .K          (K),
    .R          (R),
    .C          (C),
    .ADDR_WIDTH (ADDR_WIDTH),
    .KW         (idx_width(K)),
    .RW         (RW),
    .CW         (CW)
  ) u_idx (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (cnt_clear),
    .k_inc_i     (cnt_k_inc),
    .tile_adv_i  (cnt_tile_adv),
    .k_last_o    (k_last),
    .tile_last_o (tile_last),
    .row_o       (row),
    .col_o       (col),
    .addr_a_o    (addr_a),
    .addr_b_o    (addr_b)
  );

  // Scheduler FSM with registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      busy           <= 1'b0;
      done           <= 1'b0;
      addr_valid     <= 1'b0;
      core_rst_n     <= 1'b0;
      core_reset_acc <= 1'b1;
      tile_valid     <= 1'b0;
      tile_row       <= '0;
      tile_col       <= '0;
    end else begin
      done       <= 1'b0;
      tile_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q        <= StLoad;
            busy           <= 1'b1;
            addr_valid     <= 1'b1;
            core_reset_acc <= 1'b1;
          end
        end
        StLoad: begin
          if (addr_ready) begin
            state_q        <= StRun;
            addr_valid     <= 1'b0;
            core_rst_n     <= 1'b1;
            core_reset_acc <= 1'b0;
          end
        end
        StRun: begin
          if (systolic_finish) begin
            core_rst_n <= 1'b0;
            state_q    <= k_last ? StDrain : StClear;
          end
        end
        StClear: begin
          // Accumulator kept (core_reset_acc stays low): next inner block adds on.
          state_q    <= StLoad;
          addr_valid <= 1'b1;
        end
        StDrain: ;
        StFin: begin
          state_q        <= StIdle;
          done           <= 1'b1;
          busy           <= 1'b0;
          core_reset_acc <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
      // Tile completion overrides the per-state next state above.
      if (cnt_tile_adv) begin
        tile_valid <= 1'b1;
        tile_row   <= row;
        tile_col   <= col;
        core_rst_n <= 1'b0;
        if (tile_last) begin
          state_q <= StFin;
        end else begin
          state_q        <= StLoad;
          addr_valid     <= 1'b1;
          core_reset_acc <= 1'b1;
        end
      end
    end
  end

`ifdef MATMUL_SCHED_PERF_EN
  // Saturating busy-cycle and address-stall counters, cleared per run.
  always_ff @(posedge clk) begin
    if (rst || (state_q == StIdle && start)) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 1'b1;
      if (state_q == StLoad && !addr_ready && perf_stall != '1) perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Directed bench for matmul_tile_scheduler with K=4, R=2, C=2 and a small
// behavioural core model (finish 5 cycles after restart, accumulator done a
// few cycles later, or in the same cycle in simultaneous mode).
module tb_matmul_tile_scheduler;

  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          addr_ready = 1'b1;
  logic          busy, done, addr_valid, core_rst_n, core_reset_acc, tile_valid;
  logic [AW-1:0] addr_a, addr_b;
  logic          systolic_finish, accumulator_done;
  logic [0:0]    tile_row, tile_col;
`ifdef MATMUL_SCHED_PERF_EN
  logic [31:0]   perf_cycles, perf_stall;
`endif

  always #5 clk = ~clk;

  matmul_tile_scheduler #(
    .BLOCK_SIZE      (2),
    .INNER_DIMENSION (8),
    .ROW_SIZE_MAT_A  (4),
    .COL_SIZE_MAT_B  (4),
    .ADDR_WIDTH      (AW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .addr_valid       (addr_valid),
    .addr_ready       (addr_ready),
    .addr_a           (addr_a),
    .addr_b           (addr_b),
    .core_rst_n       (core_rst_n),
    .core_reset_acc   (core_reset_acc),
    .systolic_finish  (systolic_finish),
    .accumulator_done (accumulator_done),
    .tile_valid       (tile_valid),
    .tile_row         (tile_row),
    .tile_col         (tile_col)
`ifdef MATMUL_SCHED_PERF_EN
    ,
    .perf_cycles      (perf_cycles),
    .perf_stall       (perf_stall)
`endif
  );

  // Core model.
  logic [3:0]    core_cnt;
  logic [1:0]    acc_dly;
  logic [AW-1:0] hs_k;
  logic          sim_mode = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      core_cnt <= '0;
      acc_dly  <= '0;
      hs_k     <= '0;
    end else begin
      if (!core_rst_n)          core_cnt <= '0;
      else if (core_cnt != 4'hf) core_cnt <= core_cnt + 1'b1;
      if (addr_valid && addr_ready) hs_k <= addr_a % 4;
      if (systolic_finish && hs_k == 3 && !sim_mode) acc_dly <= 2'd3;
      else if (acc_dly != 0)                         acc_dly <= acc_dly - 1'b1;
    end
  end

  assign systolic_finish  = core_rst_n && core_cnt >= 4;
  assign accumulator_done = sim_mode ? (systolic_finish && hs_k == 3) : (acc_dly == 2'd1);

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Transaction log and cycle-relative protocol checks.
  int  log_a[$];
  int  log_b[$];
  int  log_tr[$];
  int  log_tc[$];
  int  done_cnt = 0;
  int  busy_cnt = 0;
  bit  chk_hs = 0, chk_tv = 0, chk_done = 0;

  always @(negedge clk) begin
    if (chk_hs)   check("rst_n_after_hs", core_rst_n, 1);
    if (chk_tv)   check("tv_after_acc", tile_valid, 1);
    if (chk_done) check("done_after_last", done, 1);
    chk_hs   = addr_valid && addr_ready && !rst;
    chk_tv   = accumulator_done && !rst;
    chk_done = tile_valid && tile_row == 1 && tile_col == 1 && !rst;
    if (addr_valid && addr_ready) begin
      log_a.push_back(int'(addr_a));
      log_b.push_back(int'(addr_b));
      check("acc_clr_at_k0", core_reset_acc, (addr_a % 4 == 0) ? 1 : 0);
    end
    if (tile_valid) begin
      log_tr.push_back(int'(tile_row));
      log_tc.push_back(int'(tile_col));
    end
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  end

  int exp_a[16] = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5, 6, 7, 4, 5, 6, 7};
  int exp_b[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 7};
  int exp_tr[4] = '{0, 0, 1, 1};
  int exp_tc[4] = '{0, 1, 0, 1};

  task automatic clear_log;
    log_a.delete();
    log_b.delete();
    log_tr.delete();
    log_tc.delete();
    done_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic pulse_start;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, done_cnt, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_run(input string tag);
    check({tag, "_n_hs"}, log_a.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < log_a.size()) begin
        check({tag, "_addr_a"}, log_a[i], exp_a[i]);
        check({tag, "_addr_b"}, log_b[i], exp_b[i]);
      end
    end
    check({tag, "_n_tiles"}, log_tr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_tr.size()) begin
        check({tag, "_tile_row"}, log_tr[i], exp_tr[i]);
        check({tag, "_tile_col"}, log_tc[i], exp_tc[i]);
      end
    end
    check({tag, "_done_cnt"}, done_cnt, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr_valid", addr_valid, 0);
    check("rst_tile_valid", tile_valid, 0);
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_reset_acc", core_reset_acc, 1);
    check("rst_addr_a", addr_a, 0);
    check("rst_addr_b", addr_b, 0);
    check("rst_tile_rc", {tile_row, tile_col}, 0);

    // Scenario 1: full run, addr_ready tied high.
    clear_log();
    pulse_start();
    check("s1_busy_n1", busy, 1);
    check("s1_valid_n1", addr_valid, 1);
    check("s1_acc_n1", core_reset_acc, 1);
    check("s1_rst_n_n1", core_rst_n, 0);
    wait_done("s1");
    check_run("s1");
    check("s1_idle_busy", busy, 0);

    // Scenario 2: address stall for 10 cycles in the first LOAD.
    clear_log();
    addr_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("s2_stall_valid", addr_valid, 1);
      check("s2_stall_a", addr_a, 0);
      check("s2_stall_b", addr_b, 0);
      check("s2_stall_rst_n", core_rst_n, 0);
      @(posedge clk);
    end
    #1 addr_ready = 1'b1;
    wait_done("s2");
    check_run("s2");
`ifdef MATMUL_SCHED_PERF_EN
    check("s2_perf_stall", perf_stall, 10);
    check("s2_perf_cycles", perf_cycles, busy_cnt);
`endif

    // Scenario 3: finish and accumulator done in the same cycle.
    clear_log();
    sim_mode = 1'b1;
    pulse_start();
    wait_done("s3");
    check_run("s3");
    sim_mode = 1'b0;

    // Scenario 4: reset during RUN of tile (1,0), then restart.
    clear_log();
    pulse_start();
    begin
      int  n = 0;
      bit  found = 0;
      while (!found && n < 2000) begin
        @(negedge clk);
        found = addr_valid && addr_ready && addr_a == 4 && addr_b == 0;
        n++;
      end
      check("s4_found_tile10", found, 1);
    end
    @(posedge clk);
    #1;
    clear_log();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("s4_busy", busy, 0);
    check("s4_core_rst_n", core_rst_n, 0);
    check("s4_reset_acc", core_reset_acc, 1);
    check("s4_addr_valid", addr_valid, 0);
    repeat (30) @(posedge clk);
    #1;
    check("s4_no_done", done_cnt, 0);
    check("s4_no_tiles", log_tr.size(), 0);
    check("s4_no_hs", log_a.size(), 0);
    clear_log();
    pulse_start();
    wait_done("s4");
    check_run("s4");

    // Scenario 5: start pulses while busy are ignored.
    clear_log();
    pulse_start();
    repeat (7) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("s5");
    check_run("s5");
    check("s5_idle_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
